// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive sequencer
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_CHECK  = 3'd5
    } rx_state_t;

    localparam int PAR_ERR_IDX  = 0;
    localparam int STOP_ERR_IDX = 1;
    localparam int DATA_W       = 8;

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - multi-stage synchronizer for the serial line, resets to idle-high
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receive sequencer with host holding register
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_baud_tick,
    input  logic              i_rx,
    input  logic              i_par_en,
    input  logic              i_done_flag,
    input  logic [1:0]        i_error_flag,
    input  logic [DATA_W-1:0] i_checked_data,
    input  logic              i_rd_ack,
    output logic              o_check_en,
    output logic              o_par_en,
    output logic [DATA_W-1:0] o_raw_data,
    output logic              o_parity_bit,
    output logic              o_stop_bit,
    output logic [DATA_W-1:0] o_rx_data,
    output logic [1:0]        o_rx_err,
    output logic              o_rx_valid,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic             rx_s;
    logic             unused_done;

    // Capture is unconditional at the end of CHECK; the accept flag is informational.
    assign unused_done = i_done_flag;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_d      (i_rx),
        .o_q      (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            o_check_en   <= 1'b0;
            o_par_en     <= 1'b0;
            o_raw_data   <= '0;
            o_parity_bit <= 1'b0;
            o_stop_bit   <= 1'b1;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_baud_tick && !rx_s) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        o_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (i_baud_tick) begin
                        if (tick_cnt == MID_CNT) begin
                            if (rx_s) begin
                                state  <= ST_IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                o_par_en <= i_par_en;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= ST_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST_CNT) begin
                            o_raw_data[bit_cnt] <= rx_s;
                            bit_cnt             <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= o_par_en ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST_CNT) begin
                            o_parity_bit <= rx_s;
                            state        <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST_CNT) begin
                            o_stop_bit <= rx_s;
                            o_check_en <= 1'b1;
                            state      <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    o_check_en <= 1'b0;
                    o_busy     <= 1'b0;
                    tick_cnt   <= '0;
                    state      <= ST_IDLE;
                end
                default: begin
                    o_check_en <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Host holding register: a capture takes priority over a same-cycle acknowledge.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_rx_data  <= '0;
            o_rx_err   <= '0;
            o_rx_valid <= 1'b0;
            o_overrun  <= 1'b0;
        end else if (state == ST_CHECK) begin
            o_rx_data  <= i_checked_data;
            o_rx_err   <= i_error_flag;
            o_rx_valid <= 1'b1;
            if (i_rd_ack) begin
                o_overrun <= 1'b0;
            end else if (o_rx_valid) begin
                o_overrun <= 1'b1;
            end
        end else if (i_rd_ack) begin
            o_rx_valid <= 1'b0;
            o_overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int OS = 16;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_baud_tick = 1'b0;
    logic        i_rx = 1'b1;
    logic        i_par_en = 1'b0;
    logic        i_done_flag;
    logic [1:0]  i_error_flag;
    logic [7:0]  i_checked_data;
    logic        i_rd_ack = 1'b0;
    logic        o_check_en;
    logic        o_par_en;
    logic [7:0]  o_raw_data;
    logic        o_parity_bit;
    logic        o_stop_bit;
    logic [7:0]  o_rx_data;
    logic [1:0]  o_rx_err;
    logic        o_rx_valid;
    logic        o_overrun;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int check_pulses = 0;
    int lat_fail = 0;
    logic prev_chk = 1'b0;
    int tick_div = 0;
    int base;

    uart_rx_ctrl #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .i_clk          (i_clk),
        .i_arst_n       (i_arst_n),
        .i_baud_tick    (i_baud_tick),
        .i_rx           (i_rx),
        .i_par_en       (i_par_en),
        .i_done_flag    (i_done_flag),
        .i_error_flag   (i_error_flag),
        .i_checked_data (i_checked_data),
        .i_rd_ack       (i_rd_ack),
        .o_check_en     (o_check_en),
        .o_par_en       (o_par_en),
        .o_raw_data     (o_raw_data),
        .o_parity_bit   (o_parity_bit),
        .o_stop_bit     (o_stop_bit),
        .o_rx_data      (o_rx_data),
        .o_rx_err       (o_rx_err),
        .o_rx_valid     (o_rx_valid),
        .o_overrun      (o_overrun),
        .o_busy         (o_busy)
    );

    // Checker stand-in: even parity, stop must be 1, data forced to 0xFF on any error.
    always_comb begin
        i_error_flag = 2'b00;
        i_error_flag[PAR_ERR_IDX]  = o_par_en && ((^o_raw_data) ^ o_parity_bit);
        i_error_flag[STOP_ERR_IDX] = !o_stop_bit;
        i_checked_data = (i_error_flag != 2'b00) ? 8'hFF : o_raw_data;
        i_done_flag = o_check_en;
    end

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        tick_div    <= (tick_div == 3) ? 0 : tick_div + 1;
        i_baud_tick <= (tick_div == 3);
    end

    always @(negedge i_clk) begin
        if (o_check_en) check_pulses++;
        if (prev_chk && (!o_rx_valid || o_check_en)) lat_fail++;
        prev_chk = o_check_en;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge i_clk);
            #1;
            if (i_baud_tick) k++;
        end
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_present,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_present) send_bit(par_bit);
        send_bit(stop_bit);
        i_rx = 1'b1;
        wait_ticks(2 * OS);
    endtask

    task automatic ack;
        @(posedge i_clk);
        #1 i_rd_ack = 1'b1;
        @(posedge i_clk);
        #1 i_rd_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst_rx_data", o_rx_data, 8'h00);
        check_eq("rst_rx_valid", o_rx_valid, 0);
        check_eq("rst_stop_bit", o_stop_bit, 1);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_check_en", o_check_en, 0);
        i_arst_n = 1'b1;
        wait_ticks(4);

        // 0xA5, parity present, correct even parity
        i_par_en = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check_eq("a5_pulses", check_pulses, 1);
        check_eq("a5_raw", o_raw_data, 8'hA5);
        check_eq("a5_data", o_rx_data, 8'hA5);
        check_eq("a5_err", o_rx_err, 2'b00);
        check_eq("a5_valid", o_rx_valid, 1);
        check_eq("a5_busy", o_busy, 0);
        ack();
        check_eq("a5_ack_valid", o_rx_valid, 0);

        // same byte, wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        check_eq("a5p_pulses", check_pulses, 2);
        check_eq("a5p_parbit", o_parity_bit, 1);
        check_eq("a5p_err", o_rx_err, 2'b01);
        check_eq("a5p_data", o_rx_data, 8'hFF);
        ack();

        // 0x3C, no parity, bad stop; par_en raised mid-frame must be ignored
        i_par_en = 1'b0;
        send_bit(1'b0);
        i_par_en = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(logic'((8'h3C >> i) & 1));
        send_bit(1'b0);
        i_rx = 1'b1;
        wait_ticks(2 * OS);
        i_par_en = 1'b0;
        check_eq("3c_par_en", o_par_en, 0);
        check_eq("3c_stop", o_stop_bit, 0);
        check_eq("3c_err", o_rx_err, 2'b10);
        check_eq("3c_data", o_rx_data, 8'hFF);
        check_eq("3c_raw", o_raw_data, 8'h3C);
        ack();

        // short low glitch is a false start
        base = check_pulses;
        i_rx = 1'b0;
        wait_ticks(OS / 4);
        i_rx = 1'b1;
        check_eq("glitch_busy_hi", o_busy, 1);
        wait_ticks(OS / 2);
        check_eq("glitch_busy_lo", o_busy, 0);
        wait_ticks(OS);
        check_eq("glitch_pulses", check_pulses, base);
        check_eq("glitch_valid", o_rx_valid, 0);

        // back-to-back frames without acknowledge
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_first", o_overrun, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_data", o_rx_data, 8'h22);
        check_eq("ovr_set", o_overrun, 1);
        check_eq("ovr_valid", o_rx_valid, 1);
        ack();
        check_eq("ovr_ack_valid", o_rx_valid, 0);
        check_eq("ovr_ack_clr", o_overrun, 0);
        ack();
        check_eq("ack_idle_valid", o_rx_valid, 0);

        // leave one frame pending, then reset in the middle of data bit 4
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        base = check_pulses;
        i_par_en = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(logic'((8'h5A >> i) & 1));
        i_rx = 1'b1;
        wait_ticks(OS / 2);
        i_arst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("mrst_raw", o_raw_data, 8'h00);
        check_eq("mrst_data", o_rx_data, 8'h00);
        check_eq("mrst_valid", o_rx_valid, 0);
        check_eq("mrst_par_en", o_par_en, 0);
        check_eq("mrst_stop", o_stop_bit, 1);
        check_eq("mrst_busy", o_busy, 0);
        i_arst_n = 1'b1;
        i_par_en = 1'b0;
        wait_ticks(2 * OS);
        check_eq("mrst_pulses", check_pulses, base);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check_eq("post_pulses", check_pulses, base + 1);
        check_eq("post_data", o_rx_data, 8'h5A);
        check_eq("post_err", o_rx_err, 2'b00);
        check_eq("post_valid", o_rx_valid, 1);
        check_eq("latency", lat_fail, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
